// File: rtl/nexys_starship_pkg.sv
// Shared constants, state encoding and combo helpers for the repair-combo arbiter.
package nexys_starship_pkg;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned COMBO_W = 4;

    localparam int unsigned IDX_TR = 0;
    localparam int unsigned IDX_BR = 1;
    localparam int unsigned IDX_LR = 2;
    localparam int unsigned IDX_RR = 3;

    localparam logic [COMBO_W-1:0] COMBO_NONE = 4'h0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_PICK  = 2'd1,
        ARB_CHECK = 2'd2,
        ARB_GRANT = 2'd3
    } arb_state_t;

    // Zero means "no combo", so a zero PRNG sample is remapped to 1.
    function automatic logic [COMBO_W-1:0] first_cand(input logic [COMBO_W-1:0] hex);
        return (hex == COMBO_NONE) ? COMBO_W'(1) : hex;
    endfunction

    function automatic logic [COMBO_W-1:0] next_cand(input logic [COMBO_W-1:0] c);
        return (c == '1) ? COMBO_W'(1) : c + COMBO_W'(1);
    endfunction

endpackage

// File: rtl/nexys_starship_rr_pick.sv
// Combinational 4-way round-robin first-one finder starting at ptr.
module nexys_starship_rr_pick
    import nexys_starship_pkg::*;
(
    input  logic [N_REQ-1:0] eligible,
    input  logic [1:0]       ptr,
    output logic [1:0]       sel,
    output logic             any
);

    always_comb begin
        logic [1:0] idx;
        idx = '0;
        sel = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!any && eligible[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nexys_starship_combo_arb.sv
// Round-robin arbiter that hands each repair unit a unique non-zero combo
// taken from the shared PRNG and holds it until the unit releases it.
module nexys_starship_combo_arb
    import nexys_starship_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               play_flag,
    input  logic               gameover_ctrl,
    input  logic [COMBO_W-1:0] random_hex,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   releases,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   busy,
    output logic [COMBO_W-1:0] TR_combo,
    output logic [COMBO_W-1:0] BR_combo,
    output logic [COMBO_W-1:0] LR_combo,
    output logic [COMBO_W-1:0] RR_combo
);

    arb_state_t         state;
    logic [1:0]         ptr;
    logic [1:0]         sel;
    logic [COMBO_W-1:0] cand;
    logic [COMBO_W-1:0] combo [N_REQ];

    logic [N_REQ-1:0]   eligible;
    logic [1:0]         pick_sel;
    logic               pick_any;
    logic               collide;

    assign eligible = (play_flag && !gameover_ctrl) ? (req & ~busy) : '0;

    nexys_starship_rr_pick u_rr_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .sel      (pick_sel),
        .any      (pick_any)
    );

    // The requester's own slot is never busy here, but it is excluded anyway.
    always_comb begin
        collide = 1'b0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if ((2'(j) != sel) && busy[j] && (combo[j] == cand)) begin
                collide = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (state == ARB_GRANT) begin
            gnt[sel] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ARB_IDLE;
            ptr   <= '0;
            sel   <= '0;
            cand  <= '0;
            busy  <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                combo[i] <= COMBO_NONE;
            end
        end else if (gameover_ctrl) begin
            state <= ARB_IDLE;
            busy  <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                combo[i] <= COMBO_NONE;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (releases[i] && busy[i]) begin
                    busy[i]  <= 1'b0;
                    combo[i] <= COMBO_NONE;
                end
            end
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        sel   <= pick_sel;
                        state <= ARB_PICK;
                    end
                end
                ARB_PICK: begin
                    cand  <= first_cand(random_hex);
                    state <= ARB_CHECK;
                end
                ARB_CHECK: begin
                    if (collide) begin
                        cand <= next_cand(cand);
                    end else begin
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    busy[sel]  <= 1'b1;
                    combo[sel] <= cand;
                    ptr        <= sel + 2'd1;
                    state      <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign TR_combo = combo[IDX_TR];
    assign BR_combo = combo[IDX_BR];
    assign LR_combo = combo[IDX_LR];
    assign RR_combo = combo[IDX_RR];

endmodule

// File: tb/tb_nexys_starship_combo_arb.sv
// Directed bench for the combo arbiter: latency, collisions, zero remap, round-robin, abort and reset.
module tb_nexys_starship_combo_arb;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       play_flag;
    logic       gameover_ctrl;
    logic [3:0] random_hex;
    logic [3:0] req;
    logic [3:0] releases;
    logic [3:0] gnt;
    logic [3:0] busy;
    logic [3:0] TR_combo, BR_combo, LR_combo, RR_combo;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    nexys_starship_combo_arb dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .play_flag     (play_flag),
        .gameover_ctrl (gameover_ctrl),
        .random_hex    (random_hex),
        .req           (req),
        .releases      (releases),
        .gnt           (gnt),
        .busy          (busy),
        .TR_combo      (TR_combo),
        .BR_combo      (BR_combo),
        .LR_combo      (LR_combo),
        .RR_combo      (RR_combo)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output int n, output logic [3:0] g);
        n = 0;
        g = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (gnt !== 4'b0000) begin
                g = gnt;
                break;
            end
        end
    endtask

    // Waits for the grant, checks latency and target, drops req and checks the pulse ends.
    task automatic grant_check(input string tag, input int exp_lat, input logic [3:0] exp_gnt);
        int         n;
        logic [3:0] g;
        wait_gnt(n, g);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_gnt"}, g, exp_gnt);
        req = '0;
        tick();
        chk({tag, "_pulse"}, gnt, 4'b0000);
    endtask

    task automatic rel(input logic [3:0] mask);
        releases = mask;
        tick();
        releases = '0;
    endtask

    initial begin
        int         n;
        int         stray;
        logic [3:0] g;

        Reset = 1'b1; play_flag = 1'b0; gameover_ctrl = 1'b0;
        random_hex = '0; req = '0; releases = '0;
        tick(); tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 4'b0000);
        chk("rst_combos", {TR_combo, BR_combo, LR_combo, RR_combo}, 16'h0000);
        Reset = 1'b0;
        tick();

        // Basic grant, no collision: latency 3.
        play_flag = 1'b1; random_hex = 4'hA; req = 4'b0001;
        grant_check("tr_first", 3, 4'b0001);
        chk("tr_combo", TR_combo, 4'hA);
        chk("tr_busy", busy, 4'b0001);

        // One collision with TR's A.
        random_hex = 4'hA; req = 4'b0010;
        grant_check("br_coll1", 4, 4'b0010);
        chk("br_combo_b", BR_combo, 4'hB);
        chk("busy_0011", busy, 4'b0011);

        // Three collisions: A (TR), B (LR), C (RR) -> D.
        rel(4'b0010);
        chk("br_released", {busy, BR_combo}, {4'b0001, 4'h0});
        random_hex = 4'hB; req = 4'b0100;
        grant_check("lr_b", 3, 4'b0100);
        random_hex = 4'hC; req = 4'b1000;
        grant_check("rr_c", 3, 4'b1000);
        random_hex = 4'hA; req = 4'b0010;
        grant_check("br_coll3", 6, 4'b0010);
        chk("combos_abdc", {TR_combo, BR_combo, LR_combo, RR_combo}, 16'hADBC);

        // Zero remap and 15 -> 1 -> 2 wrap.
        rel(4'b1111);
        chk("all_released", busy, 4'b0000);
        random_hex = 4'h0; req = 4'b0100;
        grant_check("lr_zero", 3, 4'b0100);
        chk("lr_one", LR_combo, 4'h1);
        random_hex = 4'hF; req = 4'b0001;
        grant_check("tr_f", 3, 4'b0001);
        random_hex = 4'hF; req = 4'b1000;
        grant_check("rr_wrap", 5, 4'b1000);
        chk("combos_f012", {TR_combo, BR_combo, LR_combo, RR_combo}, 16'hF012);

        // Round-robin from reset with all four requesting.
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        chk("rst2_busy", busy, 4'b0000);
        random_hex = 4'h5; req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n, g);
            chk($sformatf("rr_order%0d", k), g, 4'b0001 << k);
        end
        req = '0;
        tick();
        chk("rr_combos", {TR_combo, BR_combo, LR_combo, RR_combo}, 16'h5678);
        chk("rr_busy", busy, 4'b1111);
        rel(4'b0011);
        req = 4'b0011;
        wait_gnt(n, g);
        chk("rr_again0", g, 4'b0001);
        wait_gnt(n, g);
        chk("rr_again1", g, 4'b0010);
        req = '0;
        tick();
        chk("rr_again_combos", {TR_combo, BR_combo, LR_combo, RR_combo}, 16'h5678);

        // Abort during CHECK.
        rel(4'b1111);
        random_hex = 4'h3; req = 4'b0001;
        grant_check("tr_3", 3, 4'b0001);
        random_hex = 4'h3; req = 4'b0010;
        tick(); tick();
        chk("abort_pre_gnt", gnt, 4'b0000);
        gameover_ctrl = 1'b1;
        tick();
        chk("abort_gnt", gnt, 4'b0000);
        chk("abort_busy", busy, 4'b0000);
        chk("abort_combos", {TR_combo, BR_combo, LR_combo, RR_combo}, 16'h0000);
        gameover_ctrl = 1'b0; req = '0;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt !== 4'b0000) stray++;
        end
        chk("abort_no_gnt", stray, 0);
        random_hex = 4'h4; req = 4'b0100;
        grant_check("post_abort", 3, 4'b0100);
        chk("post_abort_lr", LR_combo, 4'h4);

        // Ignored release and ignored request while not playing.
        rel(4'b0100);
        random_hex = 4'h9; req = 4'b0001;
        grant_check("tr_9", 3, 4'b0001);
        rel(4'b0100);
        chk("idle_release", {busy, TR_combo, LR_combo}, {4'b0001, 4'h9, 4'h0});
        play_flag = 1'b0; req = 4'b0010;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt !== 4'b0000) stray++;
        end
        chk("noplay_gnt", stray, 0);
        chk("noplay_busy", busy, 4'b0001);
        req = '0; play_flag = 1'b1;

        // Reset while GRANT is active.
        random_hex = 4'h2; req = 4'b0010;
        wait_gnt(n, g);
        chk("pre_rst_gnt", g, 4'b0010);
        Reset = 1'b1;
        #1;
        chk("midrst_gnt", gnt, 4'b0000);
        chk("midrst_busy", busy, 4'b0000);
        chk("midrst_combos", {TR_combo, BR_combo, LR_combo, RR_combo}, 16'h0000);
        req = '0;
        tick();
        Reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nexys_starship_combo_arb.md
Name: nexys_starship_combo_arb

Overview:
- Arbiter and allocator for the shared 4-bit random_hex PRNG output.
- Serves the four repair state machines (TR, BR, LR, RR).
- Grants requesters round-robin and assigns each a non-zero repair combo that differs from every combo currently in use.
- Holds each combo until that repair unit releases it, and drives the per-room combo buses to the VGA controller.

Parameters:
- N_REQ, 4, number of repair requesters; fixed index order 0=TR, 1=BR, 2=LR, 3=RR.
- COMBO_W, 4, combo width (matches Sw3..Sw0).

Ports:
- Clk  in  1  system clock (100 MHz sys_clk).
- Reset  in  1  asynchronous, active-high reset (BtnC).
- play_flag  in  1  game in Play state; requests are ignored when low.
- gameover_ctrl  in  1  game over; aborts any allocation and clears all allocations.
- random_hex  in  4  current PRNG value; slow-changing, sampled in PICK.
- req  in  4  level request per repair unit, bit i = unit i.
- release  in  4  single-cycle pulse; unit i finished its repair.
- gnt  out  4  one-hot, one-cycle grant pulse.
- busy  out  4  unit i currently owns a combo.
- TR_combo, BR_combo, LR_combo, RR_combo  out  4 each  held combo; 0 when not owned.

Behaviour:
- Reset (asynchronous):
  - State IDLE, ptr=0, sel=0, cand=0.
  - busy=0, gnt=0, all combos=0.
- FSM states: IDLE, PICK, CHECK, GRANT.
- IDLE:
  - eligible = req & ~busy, valid only when play_flag=1 and gameover_ctrl=0.
  - If any unit is eligible, sel = first eligible index scanning ptr, ptr+1, ... mod 4. Go to PICK.
- PICK: cand = random_hex, or 1 if random_hex=0. Go to CHECK.
- CHECK:
  - Collision = cand equals the combo of any unit j≠sel with busy[j]=1.
  - On collision: cand = cand+1, wrapping 15 to 1 (0 is never a candidate); stay in CHECK.
  - Otherwise go to GRANT.
  - At most 3 units are busy, so CHECK exits within 4 cycles.
- GRANT:
  - gnt[sel]=1 for exactly this cycle; gnt is a combinational decode of the GRANT state.
  - At the clock edge ending GRANT: combo[sel]=cand, busy[sel]=1, ptr=(sel+1) mod 4. Go to IDLE.
- Latency: with req sampled at edge t and k collisions, gnt is high in the cycle after edge t+2+k (k = 0..3).
- Release:
  - release[i] with busy[i]=1 clears busy[i] and combo[i] to 0 at the next edge. Allowed in any state.
  - release[i] with busy[i]=0 is ignored.
  - A release of unit j during CHECK takes effect on the next CHECK comparison. This is conservative; a stale collision only costs one extra cycle.
- req[i] while busy[i]=1 is ignored (no re-grant).
- Requests that drop before IDLE samples them are lost. After IDLE samples a request, the grant completes even if req drops.
- gameover_ctrl=1 in any state, at the next edge:
  - State=IDLE, busy=0, all combos=0.
  - No gnt is issued; ptr is kept.
  - Priority: gameover over release over grant.
- play_flag low mid-allocation does not abort; only gameover_ctrl and Reset abort.
- Invariant: for every pair of units i≠j both busy, combo[i]≠combo[j], and both combos are non-zero.
- Reset asserted mid-operation immediately returns all outputs to their reset values.

Decomposition:
- Shared package nexys_starship_pkg holds:
  - Requester indices IDX_TR=0, IDX_BR=1, IDX_LR=2, IDX_RR=3.
  - COMBO_W=4 and COMBO_NONE=4'h0.
  - FSM state encodings ARB_IDLE, ARB_PICK, ARB_CHECK, ARB_GRANT.
- One natural sub-module: nexys_starship_rr_pick, a combinational 4-way round-robin first-one finder (inputs eligible and ptr; outputs sel and any).

Test Plan:
- Grant latency: Reset, play_flag=1, random_hex=4'hA, req=0001 -> gnt=0001 for one cycle 3 cycles after the sampling edge; TR_combo=A, busy=0001.
- Collision step: TR holds A, random_hex=A, req=0010 -> one collision, gnt=0010 at latency 4, BR_combo=B. With LR=B and RR=C also held -> BR_combo=D at latency 6.
- Zero remap: random_hex=0, req=0100 -> LR_combo=1. Hold 15 and 1 busy, random_hex=F -> cand wraps 15 to 1 to 2, combo=2.
- Round-robin order: req=1111 after Reset -> grants in order 0001, 0010, 0100, 1000, all combos distinct. Then release 0011 and re-request 0011 -> TR granted before BR (ptr=0).
- Abort: gameover_ctrl=1 during CHECK -> no gnt pulse; next cycle busy=0, all combos=0, state IDLE.
- Ignored inputs: release[2] with busy[2]=0 -> no change. req=0001 with play_flag=0 -> no gnt over 20 cycles. Reset mid-GRANT -> gnt=0 and combos=0 immediately.
